multi_ext_int_ctrl: RTL and testbench

//   N-channel external interrupt controller for the PicoBlaze (pacoblaze) core; parametrised successor to the

---
 rtl/multi_ext_int_ctrl.sv | 151 +++++++++++++++
 tb/tb_multi_ext_int_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ext_int_ctrl.sv
// N-channel external interrupt controller for the PicoBlaze core.
// Captures edges on raw lines (optionally synchronised), keeps sticky pending
// bits, selects the lowest unmasked pending channel and hands it to the core
// as a single outstanding interrupt with a vector that holds until acked.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no interrupt outstanding; evaluating pending & mask
// ST_ASSERT  | int_out high, int_vec locked, waiting for int_ack
// ST_ACKED   | one-cycle low gap after ack before the next evaluation
module multi_ext_int_ctrl #(
  parameter int N_CH    = 8,
  parameter int SYNC_EN = 1,
  parameter int VW      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] int_inp,
  input  logic [N_CH-1:0] int_pos_en,
  input  logic [N_CH-1:0] int_neg_en,
  input  logic [N_CH-1:0] int_mask,
  input  logic [N_CH-1:0] int_clr,
  input  logic            int_ack,
  output logic            int_out,
  output logic [VW-1:0]   int_vec,
  output logic [N_CH-1:0] int_pending
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACKED  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   vec_q, vec_nxt;
  logic            ack_clear;
  logic [N_CH-1:0] line_s;
  logic [N_CH-1:0] line_prev;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] ack_mask;
  logic [N_CH-1:0] req;
  logic            req_any;
  logic [VW-1:0]   req_idx;

  // Optional 2-FF synchroniser; during reset both stages follow the raw line
  // so a level held across reset release never looks like an edge.
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [N_CH-1:0] sync1, sync2;

      // Two-stage synchroniser chain
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= int_inp;
          sync2 <= int_inp;
        end else begin
          sync1 <= int_inp;
          sync2 <= sync1;
        end
      end

      assign line_s = sync2;
    end else begin : g_nosync
      assign line_s = int_inp;
    end
  endgenerate

  // Edge-history register, preloaded with the live line during reset
  always_ff @(posedge clk) begin
    if (rst) line_prev <= int_inp;
    else     line_prev <= line_s;
  end

  assign cap = (line_s & ~line_prev & int_pos_en) |
               (~line_s & line_prev & int_neg_en);

  // One-hot clear of the serviced channel on the acknowledge edge
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      ack_mask[i] = ack_clear && (vec_q == VW'(i));
    end
  end

  // Sticky pending bits; a fresh capture beats any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~(int_clr | ack_mask)) | cap;
  end

  assign req = pend & int_mask;

  // Fixed priority: lowest requesting index wins
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_any = 1'b1;
        req_idx = VW'(i);
      end
    end
  end

  // FSM state and locked vector register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      vec_q <= '0;
    end else begin
      state <= state_nxt;
      vec_q <= vec_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    int_out   = 1'b0;
    ack_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          vec_nxt   = req_idx;
          state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Core is committed once int_out is high; mask/clear cannot retract it.
        int_out = 1'b1;
        if (int_ack) begin
          ack_clear = 1'b1;
          state_nxt = ST_ACKED;
        end
      end
      ST_ACKED: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign int_vec     = vec_q;
  assign int_pending = pend;

endmodule

// File: tb/tb_multi_ext_int_ctrl.sv
// Testbench for multi_ext_int_ctrl: one synchronised and one direct-sampled
// instance share stimulus; a history-based reference model checks both every
// cycle, a vector table and directed sequences check the key scenarios.
module tb_multi_ext_int_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] inp, pos_en, neg_en, mask, clr;
  logic       ack;

  logic       out_s, out_d;
  logic [2:0] vec_s, vec_d;
  logic [7:0] pend_s, pend_d;

  int n_checks = 0;
  int n_errors = 0;

  multi_ext_int_ctrl #(.N_CH(8), .SYNC_EN(1), .VW(3)) u_dut_s (
    .clk(clk), .rst(rst), .int_inp(inp), .int_pos_en(pos_en), .int_neg_en(neg_en),
    .int_mask(mask), .int_clr(clr), .int_ack(ack),
    .int_out(out_s), .int_vec(vec_s), .int_pending(pend_s)
  );

  multi_ext_int_ctrl #(.N_CH(8), .SYNC_EN(0), .VW(3)) u_dut_d (
    .clk(clk), .rst(rst), .int_inp(inp), .int_pos_en(pos_en), .int_neg_en(neg_en),
    .int_mask(mask), .int_clr(clr), .int_ack(ack),
    .int_out(out_d), .int_vec(vec_d), .int_pending(pend_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_smp[0] = line sampled at the latest edge, [1] the edge before, [2] before that.
  logic [7:0] m_smp [3];
  logic [7:0] m_pend [2];
  logic       m_out [2];
  logic [2:0] m_vec [2];
  int         m_cool [2];

  function automatic logic [2:0] lowest(input logic [7:0] r);
    logic [2:0] idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (r[i]) idx = 3'(i);
    return idx;
  endfunction

  task automatic model_step();
    logic [7:0] s, p, c, am, rq;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = 8'h00; m_out[k] = 1'b0; m_vec[k] = 3'd0; m_cool[k] = 0;
      end else begin
        s  = (k == 0) ? m_smp[1] : inp;
        p  = (k == 0) ? m_smp[2] : m_smp[0];
        c  = (s & ~p & pos_en) | (~s & p & neg_en);
        am = (m_out[k] && ack) ? (8'h01 << m_vec[k]) : 8'h00;
        rq = m_pend[k] & mask;
        m_pend[k] = (m_pend[k] & ~(clr | am)) | c;
        if (m_out[k]) begin
          if (ack) begin m_out[k] = 1'b0; m_cool[k] = 1; end
        end else if (m_cool[k] > 0) begin
          m_cool[k] = m_cool[k] - 1;
        end else if (rq != 8'h00) begin
          m_vec[k] = lowest(rq);
          m_out[k] = 1'b1;
        end
      end
    end
    if (rst) begin
      m_smp[0] = inp; m_smp[1] = inp; m_smp[2] = inp;
    end else begin
      m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = inp;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare both DUTs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_s_out",  {31'd0, out_s},  {31'd0, m_out[0]});
    chk("model_s_vec",  {29'd0, vec_s},  {29'd0, m_vec[0]});
    chk("model_s_pend", {24'd0, pend_s}, {24'd0, m_pend[0]});
    chk("model_d_out",  {31'd0, out_d},  {31'd0, m_out[1]});
    chk("model_d_vec",  {29'd0, vec_d},  {29'd0, m_vec[1]});
    chk("model_d_pend", {24'd0, pend_d}, {24'd0, m_pend[1]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic [7:0] inp, pos, neg, mask, clr;
    logic       ack;
    logic       out;
    logic [2:0] vec;
    logic [7:0] pend;
  } row_t;

  row_t tbl [$];

  function automatic row_t mk(input logic r, input logic [7:0] i, input logic [7:0] p,
                              input logic [7:0] n, input logic [7:0] m, input logic [7:0] c,
                              input logic a, input logic o, input logic [2:0] v,
                              input logic [7:0] pd);
    row_t x;
    x.rst = r; x.inp = i; x.pos = p; x.neg = n; x.mask = m; x.clr = c;
    x.ack = a; x.out = o; x.vec = v; x.pend = pd;
    return x;
  endfunction

  initial begin
    rst = 1'b1; inp = 8'h00; pos_en = 8'h00; neg_en = 8'h00;
    mask = 8'hFF; clr = 8'h00; ack = 1'b0;
    for (int i = 0; i < 3; i++) m_smp[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_out[k] = 1'b0; m_vec[k] = 3'd0; m_cool[k] = 0;
    end

    // ch0 rising edge through the synchroniser, ack, then ch4 falling-only capture
    //                rst  inp    pos    neg    mask   clr   ack out vec pend
    tbl.push_back(mk(1, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 0, 8'h10));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 1, 4, 8'h10));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 1, 0, 4, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00, 0, 0, 4, 8'h00));

    #1;
    foreach (tbl[r]) begin
      rst = tbl[r].rst; inp = tbl[r].inp; pos_en = tbl[r].pos; neg_en = tbl[r].neg;
      mask = tbl[r].mask; clr = tbl[r].clr; ack = tbl[r].ack;
      tick();
      chk($sformatf("tbl%0d_out", r),  {31'd0, out_s},  {31'd0, tbl[r].out});
      chk($sformatf("tbl%0d_vec", r),  {29'd0, vec_s},  {29'd0, tbl[r].vec});
      chk($sformatf("tbl%0d_pend", r), {24'd0, pend_s}, {24'd0, tbl[r].pend});
    end
    ack = 1'b0; clr = 8'h00;

    // Two channels rise together: ch2 served first, then ch5
    inp = 8'h00; pos_en = 8'hFF; neg_en = 8'h00; mask = 8'hFF;
    do_reset();
    inp = 8'h24; ticks(3);
    chk("c2_pend", {24'd0, pend_s}, 32'h24);
    tick();
    chk("c2_out1", {31'd0, out_s}, 32'd1);
    chk("c2_vec1", {29'd0, vec_s}, 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c2_pend_after_ack1", {24'd0, pend_s}, 32'h20);
    chk("c2_acked_low", {31'd0, out_s}, 32'd0);
    tick();
    chk("c2_idle_low", {31'd0, out_s}, 32'd0);
    tick();
    chk("c2_out2", {31'd0, out_s}, 32'd1);
    chk("c2_vec2", {29'd0, vec_s}, 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c2_pend_final", {24'd0, pend_s}, 32'h00);

    // Masked capture, unmask asserts; clear while masked suppresses the interrupt
    inp = 8'h00; pos_en = 8'hFF; neg_en = 8'h00; mask = 8'hF7;
    do_reset();
    inp = 8'h08; ticks(3);
    chk("c4_pend_masked", {24'd0, pend_s}, 32'h08);
    ticks(3);
    chk("c4_out_masked", {31'd0, out_s}, 32'd0);
    mask = 8'hFF; tick();
    chk("c4_out_unmasked", {31'd0, out_s}, 32'd1);
    chk("c4_vec", {29'd0, vec_s}, 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c4_pend_acked", {24'd0, pend_s}, 32'h00);
    inp = 8'h00; mask = 8'hF7; ticks(4);
    inp = 8'h08; ticks(3);
    chk("c4_pend_again", {24'd0, pend_s}, 32'h08);
    clr = 8'h08; tick(); clr = 8'h00;
    chk("c4_pend_cleared", {24'd0, pend_s}, 32'h00);
    mask = 8'hFF; ticks(3);
    chk("c4_no_irq", {31'd0, out_s}, 32'd0);

    // New ch1 edge captured on the very ack edge survives the ack clear
    inp = 8'h00; pos_en = 8'hFF; neg_en = 8'hFF; mask = 8'hFF;
    do_reset();
    inp = 8'h02; ticks(4);
    chk("c5_out1", {31'd0, out_s}, 32'd1);
    chk("c5_vec1", {29'd0, vec_s}, 32'd1);
    inp = 8'h00; ticks(2);
    chk("c5_out_held", {31'd0, out_s}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c5_pend_kept", {24'd0, pend_s}, 32'h02);
    chk("c5_acked_low", {31'd0, out_s}, 32'd0);
    tick();
    chk("c5_idle_low", {31'd0, out_s}, 32'd0);
    tick();
    chk("c5_out2", {31'd0, out_s}, 32'd1);
    chk("c5_vec2", {29'd0, vec_s}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c5_pend_final", {24'd0, pend_s}, 32'h00);

    // Reset during ASSERT with all lines high; no phantom edge afterwards
    inp = 8'h00; pos_en = 8'h01; neg_en = 8'h00; mask = 8'hFF;
    do_reset();
    inp = 8'h01; ticks(4);
    chk("c6_out_pre", {31'd0, out_s}, 32'd1);
    pos_en = 8'hFF; neg_en = 8'hFF;
    inp = 8'hFF; rst = 1'b1; tick(); rst = 1'b0;
    chk("c6_rst_out", {31'd0, out_s}, 32'd0);
    chk("c6_rst_pend", {24'd0, pend_s}, 32'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c6_hold_pend_s", {24'd0, pend_s}, 32'h00);
      chk("c6_hold_pend_d", {24'd0, pend_d}, 32'h00);
      chk("c6_hold_out_s", {31'd0, out_s}, 32'd0);
    end

    // Case 1 on the unsynchronised instance: one edge to pend, one more to int_out
    inp = 8'h00; pos_en = 8'h01; neg_en = 8'h00; mask = 8'hFF;
    do_reset();
    inp = 8'h01; tick();
    chk("c6d_pend", {24'd0, pend_d}, 32'h01);
    chk("c6d_out_low", {31'd0, out_d}, 32'd0);
    tick();
    chk("c6d_out", {31'd0, out_d}, 32'd1);
    chk("c6d_vec", {29'd0, vec_d}, 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("c6d_pend_acked", {24'd0, pend_d}, 32'h00);
    chk("c6d_out_acked", {31'd0, out_d}, 32'd0);

    // Randomised traffic checked cycle-by-cycle against the model
    inp = 8'h00;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) begin
        pos_en = 8'($urandom);
        neg_en = 8'($urandom);
      end
      if (cyc % 40 == 0) mask = 8'($urandom) | 8'($urandom);
      inp = inp ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      clr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; ack = 1'b0; clr = 8'h00;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
